// File: rtl/mips_alu.sv
// mips_alu: registered 32-bit integer ALU for the MIPS execute stage.
// Result and carry are computed combinationally and then captured on the
// rising clock edge. They appear one cycle after the inputs are sampled.
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset (clears result and carry)
//   alu_src1   operand A (rs value)
//   alu_src2   operand B (rt value or immediate)
//   alu_src3   shift amount; only bits [4:0] are used
//   operation  4-bit operation select from ALU control decode
//   alu_result registered result
//   carry      registered carry flag (ADD/SUB only, 0 otherwise)
module mips_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] alu_src1,
  input  logic [WIDTH-1:0] alu_src2,
  input  logic [WIDTH-1:0] alu_src3,
  input  logic [3:0]       operation,
  output logic [WIDTH-1:0] alu_result,
  output logic             carry
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_NOR  = 4'd5,
    OP_SLT  = 4'd6,
    OP_SLL  = 4'd7,
    OP_SRL  = 4'd8,
    OP_SRA  = 4'd9,
    OP_SLTU = 4'd10,
    OP_LUI  = 4'd11
  } op_e;

  logic [4:0]       shamt;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic             lt_signed;
  logic             lt_unsigned;
  logic [WIDTH-1:0] result_d;
  logic             carry_d;
  logic [WIDTH-6:0] unused_shamt_hi;

  assign shamt           = alu_src3[4:0];
  assign unused_shamt_hi = alu_src3[WIDTH-1:5];

  assign sum  = {1'b0, alu_src1} + {1'b0, alu_src2};
  assign diff = {1'b0, alu_src1} + {1'b0, ~alu_src2} + {{WIDTH{1'b0}}, 1'b1};

  // Differing signs decide directly; with equal signs the subtraction
  // cannot overflow, so its MSB is the true sign of A - B.
  assign lt_signed   = (alu_src1[WIDTH-1] != alu_src2[WIDTH-1]) ? alu_src1[WIDTH-1]
                                                                : diff[WIDTH-1];
  // No borrow out of A - B means A >= B.
  assign lt_unsigned = ~diff[WIDTH];

  always_comb begin
    result_d = '0;
    carry_d  = 1'b0;
    case (op_e'(operation))
      OP_ADD:  begin
        result_d = sum[WIDTH-1:0];
        carry_d  = sum[WIDTH];
      end
      OP_SUB:  begin
        result_d = diff[WIDTH-1:0];
        carry_d  = diff[WIDTH];
      end
      OP_AND:  result_d = alu_src1 & alu_src2;
      OP_OR:   result_d = alu_src1 | alu_src2;
      OP_XOR:  result_d = alu_src1 ^ alu_src2;
      OP_NOR:  result_d = ~(alu_src1 | alu_src2);
      OP_SLT:  result_d = {{(WIDTH-1){1'b0}}, lt_signed};
      OP_SLL:  result_d = alu_src2 << shamt;
      OP_SRL:  result_d = alu_src2 >> shamt;
      OP_SRA:  result_d = $unsigned($signed(alu_src2) >>> shamt);
      OP_SLTU: result_d = {{(WIDTH-1){1'b0}}, lt_unsigned};
      OP_LUI:  result_d = {alu_src2[15:0], 16'h0000};
      default: begin
        result_d = '0;
        carry_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_result <= '0;
      carry      <= 1'b0;
    end else begin
      alu_result <= result_d;
      carry      <= carry_d;
    end
  end

endmodule

// File: tb/tb_mips_alu.sv
// Testbench for mips_alu: directed vectors with hand-computed expectations,
// applied one per cycle, plus reset and input-hold sequences.
module tb_mips_alu;

  logic        clk;
  logic        rst_n;
  logic [31:0] alu_src1;
  logic [31:0] alu_src2;
  logic [31:0] alu_src3;
  logic [3:0]  operation;
  logic [31:0] alu_result;
  logic        carry;

  int checks;
  int failures;

  mips_alu #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .alu_src1   (alu_src1),
    .alu_src2   (alu_src2),
    .alu_src3   (alu_src3),
    .operation  (operation),
    .alu_result (alu_result),
    .carry      (carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] s;
    logic [31:0] exp_res;
    logic        exp_c;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic [3:0] op, logic [31:0] a, logic [31:0] b,
                              logic [31:0] s, logic [31:0] r, logic c);
    vec_t v;
    v.name = name; v.op = op; v.a = a; v.b = b; v.s = s; v.exp_res = r; v.exp_c = c;
    return v;
  endfunction

  task automatic check(string name, logic [31:0] exp_res, logic exp_c);
    checks++;
    if (alu_result !== exp_res || carry !== exp_c) begin
      failures++;
      $display("FAIL %s: result=%h carry=%b expected result=%h carry=%b",
               name, alu_result, carry, exp_res, exp_c);
    end
  endtask

  task automatic drive(logic [3:0] op, logic [31:0] a, logic [31:0] b, logic [31:0] s);
    operation = op; alu_src1 = a; alu_src2 = b; alu_src3 = s;
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    vecs.push_back(mk("add_wrap",   4'd0,  32'hFFFFFFFC, 32'h4, 32'h4, 32'h00000000, 1'b1));
    vecs.push_back(mk("sub",        4'd1,  32'hFFFFFFFC, 32'h4, 32'h4, 32'hFFFFFFF8, 1'b1));
    vecs.push_back(mk("slt",        4'd6,  32'hFFFFFFFC, 32'h4, 32'h4, 32'h00000001, 1'b0));
    vecs.push_back(mk("sltu",       4'd10, 32'hFFFFFFFC, 32'h4, 32'h4, 32'h00000000, 1'b0));
    vecs.push_back(mk("and",        4'd2,  32'hFFFFFFFC, 32'h4, 32'h4, 32'h00000004, 1'b0));
    vecs.push_back(mk("or",         4'd3,  32'hFFFFFFFC, 32'h4, 32'h4, 32'hFFFFFFFC, 1'b0));
    vecs.push_back(mk("xor",        4'd4,  32'hFFFFFFFC, 32'h4, 32'h4, 32'hFFFFFFF8, 1'b0));
    vecs.push_back(mk("nor",        4'd5,  32'hFFFFFFFC, 32'h4, 32'h4, 32'h00000003, 1'b0));
    vecs.push_back(mk("sll",        4'd7,  32'h0, 32'h4,        32'h4,  32'h00000040, 1'b0));
    vecs.push_back(mk("srl",        4'd8,  32'h0, 32'h4,        32'h4,  32'h00000000, 1'b0));
    vecs.push_back(mk("sra_neg",    4'd9,  32'h0, 32'h80000000, 32'h4,  32'hF8000000, 1'b0));
    vecs.push_back(mk("srl_msb",    4'd8,  32'h0, 32'h80000000, 32'h4,  32'h08000000, 1'b0));
    vecs.push_back(mk("sra_pos",    4'd9,  32'h0, 32'h70000000, 32'h4,  32'h07000000, 1'b0));
    vecs.push_back(mk("sll_s0",     4'd7,  32'h0, 32'h12345678, 32'h0,  32'h12345678, 1'b0));
    vecs.push_back(mk("sra_s0",     4'd9,  32'h0, 32'h80000001, 32'h0,  32'h80000001, 1'b0));
    vecs.push_back(mk("sll_s3hi",   4'd7,  32'h0, 32'h4,        32'h24, 32'h00000040, 1'b0));
    vecs.push_back(mk("srl_s3hi",   4'd8,  32'h0, 32'h80000000, 32'hFFFFFFE4, 32'h08000000, 1'b0));
    vecs.push_back(mk("add_max",    4'd0,  32'hFFFFFFFF, 32'h1, 32'h0, 32'h00000000, 1'b1));
    vecs.push_back(mk("rsvd12",     4'd12, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1F, 32'h0, 1'b0));
    vecs.push_back(mk("sub_0m1",    4'd1,  32'h0, 32'h1, 32'h0, 32'hFFFFFFFF, 1'b0));
    vecs.push_back(mk("sub_eq",     4'd1,  32'h5, 32'h5, 32'h0, 32'h00000000, 1'b1));
    vecs.push_back(mk("slt_ovf",    4'd6,  32'h80000000, 32'h1, 32'h0, 32'h00000001, 1'b0));
    vecs.push_back(mk("slt_ovf2",   4'd6,  32'h7FFFFFFF, 32'h80000000, 32'h0, 32'h00000000, 1'b0));
    vecs.push_back(mk("sltu_lt",    4'd10, 32'h1, 32'h2, 32'h0, 32'h00000001, 1'b0));
    vecs.push_back(mk("lui",        4'd11, 32'h0, 32'h1234ABCD, 32'h0, 32'hABCD0000, 1'b0));
    vecs.push_back(mk("add_c1",     4'd0,  32'h80000000, 32'h80000000, 32'h0, 32'h00000000, 1'b1));
    vecs.push_back(mk("rsvd13",     4'd13, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1F, 32'h0, 1'b0));
    vecs.push_back(mk("rsvd14",     4'd14, 32'h12345678, 32'h1, 32'h4, 32'h0, 1'b0));
    vecs.push_back(mk("add_c2",     4'd0,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 32'hFFFFFFFE, 1'b1));
    vecs.push_back(mk("rsvd15",     4'd15, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1F, 32'h0, 1'b0));
    vecs.push_back(mk("add_small",  4'd0,  32'h00000003, 32'h00000004, 32'h0, 32'h00000007, 1'b0));

    // Reset with garbage inputs while the clock runs.
    rst_n = 1'b0;
    drive(4'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hDEADBEEF);
    repeat (3) @(posedge clk);
    #1 check("reset_hold", 32'h0, 1'b0);

    // First edge after deassertion loads the current inputs.
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_load", 32'hFFFFFFFE, 1'b1);

    // Asynchronous clear between edges, no clock required.
    #2 rst_n = 1'b0;
    #1 check("async_clear", 32'h0, 1'b0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("reload_after_clear", 32'hFFFFFFFE, 1'b1);

    // Back-to-back table sweep: new op every cycle, checked one edge later.
    drive(vecs[0].op, vecs[0].a, vecs[0].b, vecs[0].s);
    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk); #1;
      if (i + 1 < vecs.size())
        drive(vecs[i+1].op, vecs[i+1].a, vecs[i+1].b, vecs[i+1].s);
      check(vecs[i].name, vecs[i].exp_res, vecs[i].exp_c);
    end

    // Inputs changed between edges must not disturb the held result.
    drive(4'd0, 32'h10, 32'h20, 32'h0);
    @(posedge clk); #1;
    drive(4'd5, 32'h0, 32'h0, 32'h0);
    #3 check("hold_between_edges", 32'h00000030, 1'b0);
    @(posedge clk); #1;
    check("hold_next_edge", 32'hFFFFFFFF, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety bound on total run time.
  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mips_alu.md
Name: mips_alu

Overview:
- Registered 32-bit integer ALU for the MIPS execute stage.
- Combines two data operands (alu_src1, alu_src2) and a shift-amount operand (alu_src3) under a 4-bit operation code.
- Result and carry flag are captured in flops and presented one clock after the inputs are sampled.
- Drives the EX/MEM boundary; the operation code comes from ALU control decode.

Parameters:
- WIDTH, 32, datapath width; all arithmetic and shift rules below assume 32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- alu_src1  input  32  operand A (rs value)
- alu_src2  input  32  operand B (rt value or immediate)
- alu_src3  input  32  shift amount; only bits [4:0] are used
- operation  input  4  operation select
- alu_result  output  32  registered result
- carry  output  1  registered carry flag

Behaviour:
- Reset: while rst_n = 0, alu_result = 0 and carry = 0, asynchronously, regardless of clk.
- Latency: on each rising clk with rst_n = 1, the flops capture f(alu_src1, alu_src2, alu_src3, operation). There is no enable and no handshake; a new operation can start every cycle.
- Operation encoding (A = alu_src1, B = alu_src2, S = alu_src3[4:0]):
  - 0 ADD: A + B; carry = bit 32 of the 33-bit sum.
  - 1 SUB: A - B, computed as A + ~B + 1; carry = bit 32 of that sum (1 = no borrow).
  - 2 AND: A & B; carry 0.
  - 3 OR: A | B; carry 0.
  - 4 XOR: A ^ B; carry 0.
  - 5 NOR: ~(A | B); carry 0.
  - 6 SLT: 1 if signed A < signed B, else 0, zero-extended to 32 bits; carry 0.
  - 7 SLL: B << S, zero fill; carry 0.
  - 8 SRL: B >> S, zero fill; carry 0.
  - 9 SRA: B >> S with sign fill from B[31]; carry 0.
  - 10 SLTU: 1 if unsigned A < unsigned B, else 0; carry 0.
  - 11 LUI: {B[15:0], 16'h0000}; carry 0.
  - 12-15 reserved: result 0, carry 0.
- Width and shift rules:
  - Arithmetic wraps modulo 2^32; no overflow output.
  - SLT must be correct when A - B overflows (compare signs, not the subtraction's MSB).
  - S = 0 passes B through unchanged.
  - alu_src3[31:5] is ignored.
- Reset mid-operation: asserting rst_n clears the outputs immediately. After deassertion, the first rising edge loads the current inputs normally.
- Inputs that change between edges have no effect until the next rising edge.

Test Plan:
- Reset: drive rst_n = 0 with garbage inputs and toggle clk -> alu_result = 0, carry = 0. Assert rst_n asynchronously between edges -> outputs clear without waiting for a clock.
- Arithmetic sweep, A = 0xFFFFFFFC, B = 4, S = 4, one op per cycle, each checked one cycle later:
  - ADD -> 0x00000000, carry 1.
  - SUB -> 0xFFFFFFF8, carry 1.
  - SLT -> 0x00000001.
  - SLTU -> 0x00000000.
- Logic with the same operands:
  - AND -> 0x00000004.
  - OR -> 0xFFFFFFFC.
  - XOR -> 0xFFFFFFF8.
  - NOR -> 0x00000003.
  - Carry 0 for all four.
- Shifts:
  - SLL, B = 4, S = 4 -> 0x00000040.
  - SRL, B = 4, S = 4 -> 0x00000000.
  - SRA, B = 0x80000000, S = 4 -> 0xF8000000.
  - SRL, B = 0x80000000, S = 4 -> 0x08000000.
  - S = 0 -> B unchanged.
  - alu_src3 = 0x00000024 -> behaves as S = 4.
- Edge cases:
  - ADD 0xFFFFFFFF + 1 -> 0, carry 1.
  - SUB 0 - 1 -> 0xFFFFFFFF, carry 0.
  - SLT with A = 0x80000000, B = 1 -> 1 (overflow case).
  - LUI with B = 0x1234ABCD -> 0xABCD0000.
  - Operation 12 through 15 -> result 0, carry 0.
- Back-to-back: change operation every cycle. Each result appears exactly one cycle after its inputs, with no bubbles and no stale carry carried over from the previous op.
